// File: rtl/fifo_frame_writer.sv
// fifo_frame_writer
//   Write-side frame producer for the async FIFO (wr_clk domain). Takes a frame
//   command carrying a payload length, then pushes [len][payload x len] and,
//   when FRAME_CSUM_EN is defined, a trailing XOR checksum word into the FIFO
//   write port. Writes are decided combinationally against i_fifo_full, so no
//   write is ever issued while the FIFO is full.
//
//   Build option: `define FRAME_CSUM_EN adds the checksum trailer word.
//
// Ports
//   wr_clk          write-domain clock
//   wr_rst          asynchronous, active-high reset
//   i_cmd_valid     frame command valid
//   i_cmd_len       payload word count
//   o_cmd_ready     command accepted on valid&ready (IDLE only)
//   i_src_valid     payload word valid
//   i_src_data      payload word
//   o_src_ready     payload word consumed on valid&ready
//   i_fifo_full     FIFO full flag
//   o_fifo_wr_en    FIFO write enable
//   o_fifo_wr_data  FIFO write data, zero when not writing
//   o_busy          high outside IDLE
//   o_frames_sent   completed-frame counter, wraps
//
// State | meaning
//   IDLE | waiting for a frame command
//   HDR  | writing the length header word
//   PAY  | forwarding payload words from the source
//   CSUM | writing the checksum trailer (FRAME_CSUM_EN only)

module fifo_frame_writer #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             wr_clk,
    input  logic             wr_rst,
    input  logic             i_cmd_valid,
    input  logic [WIDTH-1:0] i_cmd_len,
    output logic             o_cmd_ready,
    input  logic             i_src_valid,
    input  logic [WIDTH-1:0] i_src_data,
    output logic             o_src_ready,
    input  logic             i_fifo_full,
    output logic             o_fifo_wr_en,
    output logic [WIDTH-1:0] o_fifo_wr_data,
    output logic             o_busy,
    output logic [CNT_W-1:0] o_frames_sent
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_HDR  = 2'd1;
    localparam logic [1:0] S_PAY  = 2'd2;
`ifdef FRAME_CSUM_EN
    localparam logic [1:0] S_CSUM = 2'd3;
    // state entered once the last header/payload word has been written
    localparam logic [1:0] S_TAIL = S_CSUM;
`else
    localparam logic [1:0] S_TAIL = S_IDLE;
`endif

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic [WIDTH-1:0] r_remaining;
    logic [WIDTH-1:0] r_hdr;
    logic [CNT_W-1:0] r_frames_sent;
`ifdef FRAME_CSUM_EN
    logic [WIDTH-1:0] r_csum;
`endif
    logic             w_wr;
    logic [WIDTH-1:0] w_word;
    logic             w_cmd_accept;
    logic             w_last_word;

    assign w_cmd_accept = (r_state == S_IDLE) && i_cmd_valid;

    always_comb begin
        w_wr        = 1'b0;
        w_word      = '0;
        o_src_ready = 1'b0;
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (i_cmd_valid) w_state_nxt = S_HDR;
            end
            S_HDR: begin
                w_wr   = !i_fifo_full;
                w_word = r_hdr;
                if (w_wr) w_state_nxt = (r_hdr != '0) ? S_PAY : S_TAIL;
            end
            S_PAY: begin
                o_src_ready = !i_fifo_full;
                w_wr        = i_src_valid && !i_fifo_full;
                w_word      = i_src_data;
                if (w_wr && (r_remaining == WIDTH'(1))) w_state_nxt = S_TAIL;
            end
`ifdef FRAME_CSUM_EN
            S_CSUM: begin
                w_wr   = !i_fifo_full;
                w_word = r_csum;
                if (w_wr) w_state_nxt = S_IDLE;
            end
`endif
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // IDLE never writes, so a write that leads back to IDLE is the frame's last word.
    assign w_last_word = w_wr && (w_state_nxt == S_IDLE);

    always_ff @(posedge wr_clk or posedge wr_rst) begin
        if (wr_rst) begin
            r_state       <= S_IDLE;
            r_remaining   <= '0;
            r_hdr         <= '0;
            r_frames_sent <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_cmd_accept) begin
                r_remaining <= i_cmd_len;
                r_hdr       <= i_cmd_len;
            end else if ((r_state == S_PAY) && w_wr) begin
                r_remaining <= r_remaining - WIDTH'(1);
            end
            if (w_last_word) r_frames_sent <= r_frames_sent + CNT_W'(1);
        end
    end

`ifdef FRAME_CSUM_EN
    always_ff @(posedge wr_clk or posedge wr_rst) begin
        if (wr_rst) begin
            r_csum <= '0;
        end else if (w_wr) begin
            if (r_state == S_HDR) r_csum <= r_hdr;
            else if (r_state == S_PAY) r_csum <= r_csum ^ i_src_data;
        end
    end
`endif

    assign o_cmd_ready    = (r_state == S_IDLE);
    assign o_busy         = (r_state != S_IDLE);
    assign o_fifo_wr_en   = w_wr;
    assign o_fifo_wr_data = w_wr ? w_word : '0;
    assign o_frames_sent  = r_frames_sent;

endmodule

// File: tb/tb_fifo_frame_writer.sv
// Testbench for fifo_frame_writer. Inputs change at the falling edge and the
// combinational outputs are sampled 1 ns later, before the next rising edge.
// Expected FIFO streams come from a frame-format model: [len][payload][xor].

module tb_fifo_frame_writer;
    localparam int W = 8;
    localparam int C = 16;

    logic         wr_clk       = 1'b0;
    logic         wr_rst       = 1'b1;
    logic         cmd_valid    = 1'b0;
    logic [W-1:0] cmd_len      = '0;
    logic         cmd_ready;
    logic         src_valid    = 1'b0;
    logic [W-1:0] src_data     = '0;
    logic         src_ready;
    logic         fifo_full    = 1'b0;
    logic         fifo_wr_en;
    logic [W-1:0] fifo_wr_data;
    logic         busy;
    logic [C-1:0] frames_sent;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;
    int bad_full = 0;
    int bad_data = 0;
    int first_wr_cyc = 0;
    int last_wr_cyc  = 0;
    logic acc, hs;
    logic [W-1:0] got[$];
    logic [W-1:0] exp_q[$];
    logic [C-1:0] exp_frames = '0;

    fifo_frame_writer #(.WIDTH(W), .CNT_W(C)) dut (
        .wr_clk        (wr_clk),
        .wr_rst        (wr_rst),
        .i_cmd_valid   (cmd_valid),
        .i_cmd_len     (cmd_len),
        .o_cmd_ready   (cmd_ready),
        .i_src_valid   (src_valid),
        .i_src_data    (src_data),
        .o_src_ready   (src_ready),
        .i_fifo_full   (fifo_full),
        .o_fifo_wr_en  (fifo_wr_en),
        .o_fifo_wr_data(fifo_wr_data),
        .o_busy        (busy),
        .o_frames_sent (frames_sent)
    );

    always #5 wr_clk = ~wr_clk;

    // One clock cycle: drive inputs, observe the cycle's decisions, record writes.
    task automatic step(input logic cv, input logic [W-1:0] len, input logic sv,
                        input logic [W-1:0] sd, input logic full);
        @(negedge wr_clk);
        cmd_valid = cv; cmd_len = len; src_valid = sv; src_data = sd; fifo_full = full;
        #1;
        cyc++;
        acc = cmd_valid & cmd_ready;
        hs  = src_valid & src_ready;
        if (fifo_wr_en) begin
            if (got.size() == 0) first_wr_cyc = cyc;
            got.push_back(fifo_wr_data);
            last_wr_cyc = cyc;
            if (fifo_full) bad_full++;
        end else if (fifo_wr_data !== '0) begin
            bad_data++;
        end
    endtask

    // Reference frame: length word, payload words, then XOR of all of them.
    function automatic void add_frame(input logic [W-1:0] p[$]);
        logic [W-1:0] x;
        x = W'(p.size());
        exp_q.push_back(x);
        foreach (p[i]) begin
            exp_q.push_back(p[i]);
            x = x ^ p[i];
        end
`ifdef FRAME_CSUM_EN
        exp_q.push_back(x);
`endif
    endfunction

    // Issues one command and feeds its payload with random stalls and gaps.
    task automatic drive_frame(input logic [W-1:0] p[$], input int full_pct,
                               input int valid_pct, output bit timeout);
        int idx = 0;
        int budget = 0;
        bit accepted = 0;
        int target;
        logic f, v;
        target = exp_q.size();
        while ((!accepted || got.size() < target) && budget < 3000) begin
            f = ($urandom_range(99) < full_pct);
            v = (idx < p.size()) && ($urandom_range(99) < valid_pct);
            step(!accepted, W'(p.size()), v, v ? p[idx] : W'($urandom), f);
            if (acc) accepted = 1;
            if (hs) idx++;
            budget++;
        end
        timeout = (budget >= 3000);
    endtask

    task automatic test_reset();
        cmd_valid = 1'b1; src_valid = 1'b1; cmd_len = 8'h07;
        #2;
        n_chk++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL reset_cmd_ready got=%b want=1", cmd_ready); end
        n_chk++; if (src_ready !== 1'b0) begin n_fail++; $display("FAIL reset_src_ready got=%b want=0", src_ready); end
        n_chk++; if (fifo_wr_en !== 1'b0) begin n_fail++; $display("FAIL reset_wr_en got=%b want=0", fifo_wr_en); end
        n_chk++; if (fifo_wr_data !== 8'h00) begin n_fail++; $display("FAIL reset_wr_data got=%h want=00", fifo_wr_data); end
        n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b want=0", busy); end
        n_chk++; if (frames_sent !== 16'd0) begin n_fail++; $display("FAIL reset_frames got=%0d want=0", frames_sent); end
        @(negedge wr_clk);
        wr_rst = 1'b0; cmd_valid = 1'b0; src_valid = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic [W-1:0] p[5];
        foreach (p[i]) p[i] = W'($urandom);
        got.delete();
        step(1, 8'd5, 0, 8'h00, 0);
        step(0, 8'd5, 0, 8'h00, 0);
        step(0, 8'd5, 1, p[0], 0);
        step(0, 8'd5, 1, p[1], 0);
        n_chk++; if (got.size() !== 3) begin n_fail++; $display("FAIL rstmid_pre_writes got=%0d want=3", got.size()); end
        @(negedge wr_clk);
        src_valid = 1'b1; src_data = p[2]; wr_rst = 1'b1;
        #1;
        n_chk++; if (fifo_wr_en !== 1'b0) begin n_fail++; $display("FAIL rstmid_wr_en got=%b want=0", fifo_wr_en); end
        n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy got=%b want=0", busy); end
        @(negedge wr_clk);
        wr_rst = 1'b0; src_valid = 1'b0;
        #1;
        n_chk++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL rstmid_cmd_ready got=%b want=1", cmd_ready); end
        n_chk++; if (frames_sent !== exp_frames) begin n_fail++; $display("FAIL rstmid_frames got=%0d want=%0d", frames_sent, exp_frames); end
        step(0, 8'd0, 1, p[3], 0);
        n_chk++; if (fifo_wr_en !== 1'b0) begin n_fail++; $display("FAIL rstmid_abandoned got=%b want=0", fifo_wr_en); end
    endtask

    task automatic test_basic();
        logic [W-1:0] p[$];
        bit to;
        p = '{8'hA1, 8'hA2, 8'hA3};
        got.delete(); exp_q.delete();
        add_frame(p);
        drive_frame(p, 0, 100, to);
        exp_frames++;
        n_chk++; if (to) begin n_fail++; $display("FAIL basic_timeout got=timeout want=done"); end
        n_chk++; if (got.size() !== exp_q.size()) begin n_fail++; $display("FAIL basic_count got=%0d want=%0d", got.size(), exp_q.size()); end
        foreach (exp_q[i]) if (i < got.size()) begin
            n_chk++; if (got[i] !== exp_q[i]) begin n_fail++; $display("FAIL basic_word%0d got=%h want=%h", i, got[i], exp_q[i]); end
        end
        n_chk++; if (last_wr_cyc - first_wr_cyc !== exp_q.size() - 1) begin n_fail++; $display("FAIL basic_consecutive got=%0d want=%0d", last_wr_cyc - first_wr_cyc, exp_q.size() - 1); end
        step(0, 8'd0, 0, 8'h00, 0);
        n_chk++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL basic_cmd_ready got=%b want=1", cmd_ready); end
        n_chk++; if (frames_sent !== exp_frames) begin n_fail++; $display("FAIL basic_frames got=%0d want=%0d", frames_sent, exp_frames); end
    endtask

    task automatic test_full_stall();
        logic [W-1:0] p[$];
        int idx = 0;
        int k = 0;
        p = '{W'($urandom), W'($urandom), W'($urandom)};
        got.delete(); exp_q.delete();
        add_frame(p);
        step(1, 8'd3, 0, 8'h00, 0);
        for (int i = 0; i < 2; i++) begin
            step(0, 8'd3, 0, 8'h00, 1);
            n_chk++; if (fifo_wr_en !== 1'b0) begin n_fail++; $display("FAIL stall_wr_en%0d got=%b want=0", i, fifo_wr_en); end
            n_chk++; if (busy !== 1'b1) begin n_fail++; $display("FAIL stall_busy%0d got=%b want=1", i, busy); end
        end
        step(0, 8'd3, 0, 8'h00, 0);
        n_chk++; if (fifo_wr_en !== 1'b1 || fifo_wr_data !== 8'h03) begin n_fail++; $display("FAIL stall_hdr_release got=%b/%h want=1/03", fifo_wr_en, fifo_wr_data); end
        while (got.size() < exp_q.size() && k < 12) begin
            step(0, 8'd3, idx < 3, (idx < 3) ? p[idx] : 8'h00, 0);
            if (hs) idx++;
            k++;
        end
        n_chk++; if (got.size() !== exp_q.size()) begin n_fail++; $display("FAIL stall_count got=%0d want=%0d", got.size(), exp_q.size()); end
        foreach (exp_q[i]) if (i < got.size()) begin
            n_chk++; if (got[i] !== exp_q[i]) begin n_fail++; $display("FAIL stall_word%0d got=%h want=%h", i, got[i], exp_q[i]); end
        end
        exp_frames++;
        step(0, 8'd0, 0, 8'h00, 0);
        n_chk++; if (frames_sent !== exp_frames) begin n_fail++; $display("FAIL stall_frames got=%0d want=%0d", frames_sent, exp_frames); end
    endtask

    task automatic test_zero_len();
        logic [W-1:0] p[$];
        bit to;
        got.delete(); exp_q.delete();
        add_frame(p);
        drive_frame(p, 0, 100, to);
        exp_frames++;
        n_chk++; if (to) begin n_fail++; $display("FAIL zero_timeout got=timeout want=done"); end
        n_chk++; if (got.size() !== exp_q.size()) begin n_fail++; $display("FAIL zero_count got=%0d want=%0d", got.size(), exp_q.size()); end
        foreach (exp_q[i]) if (i < got.size()) begin
            n_chk++; if (got[i] !== exp_q[i]) begin n_fail++; $display("FAIL zero_word%0d got=%h want=%h", i, got[i], exp_q[i]); end
        end
        step(0, 8'd0, 0, 8'h00, 0);
        n_chk++; if (frames_sent !== exp_frames) begin n_fail++; $display("FAIL zero_frames got=%0d want=%0d", frames_sent, exp_frames); end
    endtask

    task automatic test_gap();
        logic [W-1:0] p[$];
        logic pat[4];
        int idx = 0;
        int k = 0;
        p = '{W'($urandom), W'($urandom)};
        pat = '{1'b1, 1'b0, 1'b0, 1'b1};
        got.delete(); exp_q.delete();
        add_frame(p);
        step(1, 8'd2, 0, 8'h00, 0);
        step(0, 8'd2, 0, 8'h00, 0);
        for (int i = 0; i < 4; i++) begin
            step(0, 8'd2, pat[i], pat[i] ? p[idx] : W'($urandom), 0);
            if (hs) idx++;
            n_chk++; if (fifo_wr_en !== pat[i]) begin n_fail++; $display("FAIL gap_wr_en%0d got=%b want=%b", i, fifo_wr_en, pat[i]); end
            n_chk++; if (busy !== 1'b1) begin n_fail++; $display("FAIL gap_busy%0d got=%b want=1", i, busy); end
        end
        while (got.size() < exp_q.size() && k < 4) begin
            step(0, 8'd0, 0, 8'h00, 0);
            k++;
        end
        n_chk++; if (got.size() !== exp_q.size()) begin n_fail++; $display("FAIL gap_count got=%0d want=%0d", got.size(), exp_q.size()); end
        foreach (exp_q[i]) if (i < got.size()) begin
            n_chk++; if (got[i] !== exp_q[i]) begin n_fail++; $display("FAIL gap_word%0d got=%h want=%h", i, got[i], exp_q[i]); end
        end
        exp_frames++;
        step(0, 8'd0, 0, 8'h00, 0);
        n_chk++; if (frames_sent !== exp_frames) begin n_fail++; $display("FAIL gap_frames got=%0d want=%0d", frames_sent, exp_frames); end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] p1[$];
        logic [W-1:0] p2[$];
        logic [W-1:0] all[$];
        int acc_cyc[2];
        int n_acc = 0;
        int n1, lw1 = -1, idx = 0, k = 0;
        p1 = '{W'($urandom), W'($urandom)};
        p2 = '{W'($urandom)};
        all = {p1, p2};
        got.delete(); exp_q.delete();
        add_frame(p1);
        n1 = exp_q.size();
        add_frame(p2);
        while ((n_acc < 2 || got.size() < exp_q.size()) && k < 40) begin
            step(n_acc < 2, (n_acc == 0) ? 8'd2 : 8'd1, idx < all.size(),
                 (idx < all.size()) ? all[idx] : 8'h00, 0);
            if (acc) begin acc_cyc[n_acc] = cyc; n_acc++; end
            if (hs) idx++;
            if (got.size() == n1 && lw1 < 0) lw1 = last_wr_cyc;
            k++;
        end
        n_chk++; if (n_acc !== 2) begin n_fail++; $display("FAIL b2b_accepts got=%0d want=2", n_acc); end
        if (n_acc == 2) begin
            n_chk++; if (acc_cyc[1] !== lw1 + 1) begin n_fail++; $display("FAIL b2b_accept_cycle got=%0d want=%0d", acc_cyc[1], lw1 + 1); end
        end
        n_chk++; if (got.size() !== exp_q.size()) begin n_fail++; $display("FAIL b2b_count got=%0d want=%0d", got.size(), exp_q.size()); end
        foreach (exp_q[i]) if (i < got.size()) begin
            n_chk++; if (got[i] !== exp_q[i]) begin n_fail++; $display("FAIL b2b_word%0d got=%h want=%h", i, got[i], exp_q[i]); end
        end
        exp_frames += 2;
        step(0, 8'd0, 0, 8'h00, 0);
        n_chk++; if (frames_sent !== exp_frames) begin n_fail++; $display("FAIL b2b_frames got=%0d want=%0d", frames_sent, exp_frames); end
    endtask

    task automatic test_random();
        logic [W-1:0] p[$];
        bit to;
        int len;
        for (int f = 0; f < 25; f++) begin
            len = (f == 12) ? 255 : int'($urandom_range(12));
            p.delete();
            for (int i = 0; i < len; i++) p.push_back(W'($urandom));
            got.delete(); exp_q.delete();
            add_frame(p);
            drive_frame(p, $urandom_range(50), $urandom_range(100, 40), to);
            exp_frames++;
            n_chk++; if (to) begin n_fail++; $display("FAIL rand%0d_timeout got=timeout want=done", f); end
            n_chk++; if (got.size() !== exp_q.size()) begin n_fail++; $display("FAIL rand%0d_count got=%0d want=%0d", f, got.size(), exp_q.size()); end
            foreach (exp_q[i]) if (i < got.size()) begin
                n_chk++; if (got[i] !== exp_q[i]) begin n_fail++; $display("FAIL rand%0d_word%0d got=%h want=%h", f, i, got[i], exp_q[i]); end
            end
            step(0, 8'd0, 0, 8'h00, 0);
            n_chk++; if (frames_sent !== exp_frames) begin n_fail++; $display("FAIL rand%0d_frames got=%0d want=%0d", f, frames_sent, exp_frames); end
        end
    endtask

    task automatic test_protocol_rules();
        n_chk++; if (bad_full !== 0) begin n_fail++; $display("FAIL write_while_full got=%0d want=0", bad_full); end
        n_chk++; if (bad_data !== 0) begin n_fail++; $display("FAIL idle_data_nonzero got=%0d want=0", bad_data); end
    endtask

    initial begin
        test_reset();
        test_reset_mid();
        test_basic();
        test_full_stall();
        test_zero_len();
        test_gap();
        test_back_to_back();
        test_random();
        test_protocol_rules();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
